core_seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the AsteRISC RV32I core. Captures fetched instruction words, classifies them against the RV32I baseline encodings, and walks the shared datapath through fetch, decode, execute, memory and writeback. It drives the instruction and data memory handshakes, register-file write enable and PC update select. It raises precise traps for illegal instructions, ECALL, EBREAK and data-memory timeouts, and keeps a retired-instruction counter.

---
 rtl/core_seq_ctrl_if.sv | 37 +++
 rtl/core_seq_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_seq_ctrl_if.sv
// Memory and trap handshake bundle between the AsteRISC sequencer and its
// instruction memory, data memory and trap/CSR unit.
interface core_seq_ctrl_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        trap_valid;
  logic [3:0]  trap_cause;
  logic        trap_ack;

  modport master (
    output imem_req,
    input  imem_ack,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_ack,
    output trap_valid,
    output trap_cause,
    input  trap_ack
  );

  modport slave (
    input  imem_req,
    output imem_ack,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_ack,
    input  trap_valid,
    input  trap_cause,
    output trap_ack
  );
endinterface

// File: rtl/core_seq_ctrl.sv
// AsteRISC RV32I multi-cycle sequencer: fetch, decode/classify, execute,
// memory and writeback control with precise traps and a retire counter.
// Requests, trap status, rf_we and fence_i are registered from the next state.
// pc_en/pc_sel are decoded from the current state because branch direction,
// store completion and trap acceptance are only known in the pulse cycle.
module core_seq_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rstn,
  core_seq_ctrl_if.master bus,
  input  logic            br_taken,
  output logic [31:0]     ir,
  output logic            rf_we,
  output logic            pc_en,
  output logic [1:0]      pc_sel,
  output logic            fence_i,
  output logic [63:0]     instret,
  output logic [2:0]      state
);
  typedef enum logic [2:0] {
    ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2,
    ST_MEM   = 3'd3, ST_WB     = 3'd4, ST_TRAP = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CLS_ALU = 4'd0, CLS_LOAD = 4'd1, CLS_STORE = 4'd2, CLS_BRANCH = 4'd3,
    CLS_JUMP = 4'd4, CLS_FENCE = 4'd5, CLS_FENCEI = 4'd6, CLS_ECALL = 4'd7,
    CLS_EBREAK = 4'd8, CLS_ILLEGAL = 4'd9
  } cls_t;

  // Last wait-counter value before the data access is declared faulted.
  localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 32'd1);

  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_BREAK    = 4'd3;
  localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
  localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;
  localparam logic [3:0] CAUSE_ECALL    = 4'd11;

  // Map an instruction word onto the RV32I baseline encoding classes.
  function automatic cls_t classify(input logic [31:0] w);
    logic [6:0] f7;
    logic [2:0] f3;
    cls_t       c;
    f7 = w[31:25];
    f3 = w[14:12];
    case (w[6:0])
      7'b0110111, 7'b0010111: c = CLS_ALU;
      7'b1101111:             c = CLS_JUMP;
      7'b1100111:             c = (f3 == 3'b000) ? CLS_JUMP : CLS_ILLEGAL;
      7'b1100011:             c = (f3 != 3'b010 && f3 != 3'b011) ? CLS_BRANCH : CLS_ILLEGAL;
      7'b0000011:             c = (f3 != 3'b011 && f3 != 3'b110 && f3 != 3'b111) ? CLS_LOAD : CLS_ILLEGAL;
      7'b0100011:             c = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010) ? CLS_STORE : CLS_ILLEGAL;
      7'b0010011: begin
        case (f3)
          3'b001:  c = (f7 == 7'b0000000) ? CLS_ALU : CLS_ILLEGAL;
          3'b101:  c = (f7 == 7'b0000000 || f7 == 7'b0100000) ? CLS_ALU : CLS_ILLEGAL;
          default: c = CLS_ALU;
        endcase
      end
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          c = CLS_ALU;
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          c = CLS_ALU;
        end else begin
          c = CLS_ILLEGAL;
        end
      end
      7'b0001111: begin
        if (f3 == 3'b000 && w[19:15] == 5'd0 && w[11:7] == 5'd0) begin
          c = CLS_FENCE;
        end else if (w == 32'h0000100F) begin
          c = CLS_FENCEI;
        end else begin
          c = CLS_ILLEGAL;
        end
      end
      7'b1110011: begin
        if (w == 32'h00000073) begin
          c = CLS_ECALL;
        end else if (w == 32'h00100073) begin
          c = CLS_EBREAK;
        end else begin
          c = CLS_ILLEGAL;
        end
      end
      default: c = CLS_ILLEGAL;
    endcase
    return c;
  endfunction

  state_t      state_r, state_nxt_s;
  logic [31:0] ir_r;
  logic [15:0] wait_cnt_r, wait_cnt_nxt_s;
  logic [3:0]  trap_cause_r, cause_nxt_s;
  logic [63:0] instret_r;
  logic        imem_req_r, dmem_req_r, dmem_we_r, trap_valid_r;
  logic        rf_we_r, fence_i_r;
  logic        pc_en_s, retire_s, ir_load_s, writes_rd_s;
  logic [1:0]  pc_sel_s;
  cls_t        cls_s;

  assign cls_s       = classify(ir_r);
  assign writes_rd_s = (cls_s == CLS_ALU || cls_s == CLS_LOAD || cls_s == CLS_JUMP) &&
                       (ir_r[11:7] != 5'd0);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, trap cause, wait counter and PC-update decode.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    cause_nxt_s    = trap_cause_r;
    pc_en_s        = 1'b0;
    pc_sel_s       = 2'd0;
    retire_s       = 1'b0;
    ir_load_s      = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (imem_req_r && bus.imem_ack) begin
          ir_load_s   = 1'b1;
          state_nxt_s = ST_DECODE;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (cls_s)
          CLS_ILLEGAL: begin state_nxt_s = ST_TRAP; cause_nxt_s = CAUSE_ILLEGAL; end
          CLS_ECALL:   begin state_nxt_s = ST_TRAP; cause_nxt_s = CAUSE_ECALL;   end
          CLS_EBREAK:  begin state_nxt_s = ST_TRAP; cause_nxt_s = CAUSE_BREAK;   end
          default:     state_nxt_s = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (cls_s)
          CLS_LOAD, CLS_STORE: begin
            state_nxt_s    = ST_MEM;
            wait_cnt_nxt_s = 16'd0;
          end
          CLS_BRANCH: begin
            pc_en_s     = 1'b1;
            pc_sel_s    = br_taken ? 2'd1 : 2'd0;
            retire_s    = 1'b1;
            state_nxt_s = ST_FETCH;
          end
          default: state_nxt_s = ST_WB;
        endcase
      end
      ST_MEM: begin
        if (bus.dmem_ack) begin
          if (cls_s == CLS_STORE) begin
            pc_en_s     = 1'b1;
            retire_s    = 1'b1;
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_WB;
          end
        end else if (wait_cnt_r == WAIT_LAST) begin
          state_nxt_s = ST_TRAP;
          cause_nxt_s = (cls_s == CLS_STORE) ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + 16'd1;
        end
      end
      ST_WB: begin
        pc_en_s     = 1'b1;
        pc_sel_s    = (cls_s == CLS_JUMP) ? 2'd1 : 2'd0;
        retire_s    = 1'b1;
        state_nxt_s = ST_FETCH;
      end
      ST_TRAP: begin
        if (bus.trap_ack) begin
          pc_en_s     = 1'b1;
          pc_sel_s    = 2'd2;
          state_nxt_s = ST_FETCH;
        end else begin
          state_nxt_s = ST_TRAP;
        end
      end
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // Instruction register, MEM wait counter, trap cause and retire counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ir_r         <= 32'd0;
      wait_cnt_r   <= 16'd0;
      trap_cause_r <= 4'd0;
      instret_r    <= 64'd0;
    end else begin
      if (ir_load_s) begin
        ir_r <= bus.imem_rdata;
      end else begin
        ir_r <= ir_r;
      end
      wait_cnt_r   <= wait_cnt_nxt_s;
      trap_cause_r <= cause_nxt_s;
      if (retire_s) begin
        instret_r <= instret_r + 64'd1;
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  // Requests and strobes registered from the state being entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      imem_req_r   <= 1'b0;
      dmem_req_r   <= 1'b0;
      dmem_we_r    <= 1'b0;
      trap_valid_r <= 1'b0;
      rf_we_r      <= 1'b0;
      fence_i_r    <= 1'b0;
    end else begin
      imem_req_r   <= (state_nxt_s == ST_FETCH);
      dmem_req_r   <= (state_nxt_s == ST_MEM);
      dmem_we_r    <= (state_nxt_s == ST_MEM) && (cls_s == CLS_STORE);
      trap_valid_r <= (state_nxt_s == ST_TRAP);
      rf_we_r      <= (state_nxt_s == ST_WB) && writes_rd_s;
      fence_i_r    <= (state_nxt_s == ST_EXEC) && (cls_s == CLS_FENCEI);
    end
  end

  assign bus.imem_req   = imem_req_r;
  assign bus.dmem_req   = dmem_req_r;
  assign bus.dmem_we    = dmem_we_r;
  assign bus.trap_valid = trap_valid_r;
  assign bus.trap_cause = trap_cause_r;
  assign ir             = ir_r;
  assign rf_we          = rf_we_r;
  assign fence_i        = fence_i_r;
  assign pc_en          = pc_en_s;
  assign pc_sel         = pc_sel_s;
  assign instret        = instret_r;
  assign state          = state_r;
endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl: each instruction is fetched with an
// immediate ack, strobes are logged per cycle and compared to hand-derived
// cycle numbers, counts and trap causes.
module tb_core_seq_ctrl;
  logic        clk;
  logic        rstn;
  logic        br_taken;
  logic [31:0] ir;
  logic        rf_we;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic        fence_i;
  logic [63:0] instret;
  logic [2:0]  state;

  core_seq_ctrl_if bus ();

  core_seq_ctrl #(.MEM_TIMEOUT(16)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .br_taken (br_taken),
    .ir       (ir),
    .rf_we    (rf_we),
    .pc_en    (pc_en),
    .pc_sel   (pc_sel),
    .fence_i  (fence_i),
    .instret  (instret),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-instruction observation log filled by run_instr.
  int         n_cyc, rf_cnt, rf_cyc, pc_cnt, pc_cyc, fi_cnt, fi_cyc, dreq_cnt, dwe_cnt;
  logic [1:0] pcsel_v;
  logic       trap_hit;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Starts at a negedge in FETCH with imem_req high; runs until FETCH or TRAP.
  task automatic run_instr(input logic [31:0] word, input int ack_delay,
                           input bit ack_never, input bit taken);
    bit done;
    int cyc;
    rf_cnt = 0; rf_cyc = 0; pc_cnt = 0; pc_cyc = 0; fi_cnt = 0; fi_cyc = 0;
    dreq_cnt = 0; dwe_cnt = 0; pcsel_v = 2'd3; trap_hit = 1'b0;
    done = 1'b0;
    cyc  = 1;
    br_taken       = taken;
    bus.imem_rdata = word;
    bus.imem_ack   = 1'b1;
    while (!done && cyc <= 60) begin
      if (bus.dmem_req) begin
        dreq_cnt++;
        if (bus.dmem_we) dwe_cnt++;
        bus.dmem_ack = !ack_never && (dreq_cnt > ack_delay);
      end else begin
        bus.dmem_ack = 1'b0;
      end
      #1;
      if (rf_we)   begin rf_cnt++; rf_cyc = cyc; end
      if (pc_en)   begin pc_cnt++; pc_cyc = cyc; pcsel_v = pc_sel; end
      if (fence_i) begin fi_cnt++; fi_cyc = cyc; end
      @(negedge clk);
      bus.imem_ack = 1'b0;
      cyc++;
      if (state == 3'd0) begin
        done = 1'b1;
      end else if (bus.trap_valid) begin
        done     = 1'b1;
        trap_hit = 1'b1;
      end
    end
    bus.dmem_ack = 1'b0;
    br_taken     = 1'b0;
    n_cyc        = cyc - 1;
    if (!done) check_val("instr_budget", 64'd0, 64'd1);
  endtask

  // Called right after run_instr stops in TRAP; holds, then acknowledges.
  task automatic take_trap(input string tag, input logic [3:0] cause, input int hold);
    int          held;
    logic [63:0] ret0;
    ret0 = instret;
    held = 0;
    check_val({tag, "_valid"}, {63'd0, trap_hit}, 64'd1);
    check_val({tag, "_cause"}, {60'd0, bus.trap_cause}, {60'd0, cause});
    check_val({tag, "_no_rfwe"}, rf_cnt, 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.trap_valid && state == 3'd5) held++;
    end
    check_val({tag, "_held"}, held, hold);
    bus.trap_ack = 1'b1;
    #1;
    check_val({tag, "_ack_pc_en"}, {63'd0, pc_en}, 64'd1);
    check_val({tag, "_ack_pc_sel"}, {62'd0, pc_sel}, 64'd2);
    @(negedge clk);
    bus.trap_ack = 1'b0;
    check_val({tag, "_to_fetch"}, {61'd0, state}, 64'd0);
    check_val({tag, "_valid_clr"}, {63'd0, bus.trap_valid}, 64'd0);
    check_val({tag, "_instret"}, instret, ret0);
  endtask

  initial begin
    rstn = 1'b0; br_taken = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'd0; bus.dmem_ack = 1'b0; bus.trap_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_state", {61'd0, state}, 64'd0);
    check_val("rst_imem_req", {63'd0, bus.imem_req}, 64'd0);
    check_val("rst_dmem_req", {63'd0, bus.dmem_req}, 64'd0);
    check_val("rst_instret", instret, 64'd0);
    check_val("rst_ir", {32'd0, ir}, 64'd0);
    check_val("rst_trap_valid", {63'd0, bus.trap_valid}, 64'd0);
    check_val("rst_pc_sel", {62'd0, pc_sel}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    check_val("post_rst_imem_req", {63'd0, bus.imem_req}, 64'd1);

    // ADDI x1,x0,1
    run_instr(32'h00100093, 0, 1'b0, 1'b0);
    check_val("addi_ir", {32'd0, ir}, 64'h00100093);
    check_val("addi_latency", n_cyc, 64'd4);
    check_val("addi_rfwe_cnt", rf_cnt, 64'd1);
    check_val("addi_rfwe_cyc", rf_cyc, 64'd4);
    check_val("addi_pc_en_cyc", pc_cyc, 64'd4);
    check_val("addi_pc_sel", {62'd0, pcsel_v}, 64'd0);
    check_val("addi_instret", instret, 64'd1);

    // ADDI x0,x0,0: retires, no register write
    run_instr(32'h00000013, 0, 1'b0, 1'b0);
    check_val("nop_rfwe_cnt", rf_cnt, 64'd0);
    check_val("nop_pc_en_cnt", pc_cnt, 64'd1);
    check_val("nop_instret", instret, 64'd2);

    // BEQ taken / not taken
    run_instr(32'h00000063, 0, 1'b0, 1'b1);
    check_val("beq_t_latency", n_cyc, 64'd3);
    check_val("beq_t_pc_en_cyc", pc_cyc, 64'd3);
    check_val("beq_t_pc_sel", {62'd0, pcsel_v}, 64'd1);
    check_val("beq_t_rfwe_cnt", rf_cnt, 64'd0);
    check_val("beq_t_instret", instret, 64'd3);
    run_instr(32'h00000063, 0, 1'b0, 1'b0);
    check_val("beq_nt_pc_sel", {62'd0, pcsel_v}, 64'd0);
    check_val("beq_nt_pc_en_cyc", pc_cyc, 64'd3);
    check_val("beq_nt_instret", instret, 64'd4);

    // LW with three wait cycles
    run_instr(32'h00002083, 3, 1'b0, 1'b0);
    check_val("lw_dreq_cycles", dreq_cnt, 64'd4);
    check_val("lw_dmem_we", dwe_cnt, 64'd0);
    check_val("lw_rfwe_cyc", rf_cyc, 64'd8);
    check_val("lw_latency", n_cyc, 64'd8);
    check_val("lw_instret", instret, 64'd5);

    // SW zero-wait
    run_instr(32'h00102023, 0, 1'b0, 1'b0);
    check_val("sw_latency", n_cyc, 64'd4);
    check_val("sw_pc_en_cyc", pc_cyc, 64'd4);
    check_val("sw_dmem_we", dwe_cnt, 64'd1);
    check_val("sw_rfwe_cnt", rf_cnt, 64'd0);
    check_val("sw_instret", instret, 64'd6);

    // JAL x1: writes link, PC from target
    run_instr(32'h000000EF, 0, 1'b0, 1'b0);
    check_val("jal_latency", n_cyc, 64'd4);
    check_val("jal_pc_sel", {62'd0, pcsel_v}, 64'd1);
    check_val("jal_rfwe_cyc", rf_cyc, 64'd4);
    check_val("jal_instret", instret, 64'd7);

    // SW with no ack: access fault after 16 request cycles
    run_instr(32'h00102023, 0, 1'b1, 1'b0);
    check_val("swto_dreq_cycles", dreq_cnt, 64'd16);
    check_val("swto_dmem_we", dwe_cnt, 64'd16);
    check_val("swto_pc_en_cnt", pc_cnt, 64'd0);
    take_trap("swto", 4'd7, 1);
    check_val("swto_instret", instret, 64'd7);

    // Illegal and environment instructions
    run_instr(32'h00000000, 0, 1'b0, 1'b0);
    check_val("zero_trap_cyc", n_cyc, 64'd2);
    take_trap("zero", 4'd2, 10);
    run_instr(32'h40101093, 0, 1'b0, 1'b0);
    take_trap("slli_f7", 4'd2, 2);
    run_instr(32'h00000073, 0, 1'b0, 1'b0);
    take_trap("ecall", 4'd11, 2);
    run_instr(32'h00100073, 0, 1'b0, 1'b0);
    take_trap("ebreak", 4'd3, 2);
    check_val("env_instret", instret, 64'd7);

    // FENCE_I
    run_instr(32'h0000100F, 0, 1'b0, 1'b0);
    check_val("fencei_cnt", fi_cnt, 64'd1);
    check_val("fencei_cyc", fi_cyc, 64'd3);
    check_val("fencei_latency", n_cyc, 64'd4);
    check_val("fencei_rfwe_cnt", rf_cnt, 64'd0);
    check_val("fencei_instret", instret, 64'd8);

    // Reset while waiting in MEM
    bus.imem_rdata = 32'h00002083;
    bus.imem_ack   = 1'b1;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("midmem_state", {61'd0, state}, 64'd3);
    check_val("midmem_dreq", {63'd0, bus.dmem_req}, 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check_val("async_rst_dreq", {63'd0, bus.dmem_req}, 64'd0);
    check_val("async_rst_state", {61'd0, state}, 64'd0);
    check_val("async_rst_imem_req", {63'd0, bus.imem_req}, 64'd0);
    check_val("async_rst_instret", instret, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_val("rerun_imem_req", {63'd0, bus.imem_req}, 64'd1);
    check_val("rerun_state", {61'd0, state}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
